// File: rtl/mem_arbiter_if.sv
// Bus bundle for the fetch/data/memory arbiter: two requester ports and one memory port.
// The arbiter uses the slave view; the requesters and memory use the master view.
interface mem_arbiter_if #(
  parameter int AW = 19,
  parameter int DW = 19
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic [DW-1:0] if_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] d_rdata;

  logic          err;

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    output if_ack, if_rdata, d_ack, d_rdata, err,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    input  if_ack, if_rdata, d_ack, d_rdata, err,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between instruction fetch and data
// accesses; one access in flight, with a BUSY timeout that completes the access with err.
module mem_arbiter #(
  parameter int AW      = 19,
  parameter int DW      = 19,
  parameter int TIMEOUT = 16
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          grant;       // 0 = fetch, 1 = data
  logic          last_grant;  // 0 = fetch, 1 = data
  logic          pick_data;

  // A lone request wins outright; under contention the side not granted last time wins.
  assign pick_data = bus.d_req && (!bus.if_req || !last_grant);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      grant         <= 1'b0;
      last_grant    <= 1'b0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= {AW{1'b0}};
      bus.mem_wdata <= {DW{1'b0}};
      bus.if_ack    <= 1'b0;
      bus.d_ack     <= 1'b0;
      bus.err       <= 1'b0;
      bus.if_rdata  <= {DW{1'b0}};
      bus.d_rdata   <= {DW{1'b0}};
    end else begin
      bus.if_ack <= 1'b0;
      bus.d_ack  <= 1'b0;
      bus.err    <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.if_req || bus.d_req) begin
            grant         <= pick_data;
            last_grant    <= pick_data;
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= pick_data && bus.d_we;
            bus.mem_addr  <= pick_data ? bus.d_addr : bus.if_addr;
            bus.mem_wdata <= pick_data ? bus.d_wdata : {DW{1'b0}};
            cnt           <= '0;
            state         <= BUSY;
          end
        end
        BUSY: begin
          if (bus.mem_ready) begin
            bus.mem_req <= 1'b0;
            if (!grant) begin
              bus.if_rdata <= bus.mem_rdata;
              bus.if_ack   <= 1'b1;
            end else begin
              if (!bus.mem_we) bus.d_rdata <= bus.mem_rdata;
              bus.d_ack <= 1'b1;
            end
            state <= RESP;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            // Abort: loads return zero, a store leaves the previous load data alone.
            bus.mem_req <= 1'b0;
            bus.err     <= 1'b1;
            if (!grant) begin
              bus.if_rdata <= {DW{1'b0}};
              bus.if_ack   <= 1'b1;
            end else begin
              if (!bus.mem_we) bus.d_rdata <= {DW{1'b0}};
              bus.d_ack <= 1'b1;
            end
            state <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: requester tasks push expected acks, a monitor pops them,
// and a memory responder model checks the memory-side bus and inserts wait states.
module tb_mem_arbiter;

  localparam int AW = 19;
  localparam int DW = 19;
  localparam int TO = 16;

  typedef struct {
    bit            dat;
    bit            err;
    logic [DW-1:0] rdata;
    int            cyc;
  } exp_t;

  logic clk;
  logic reset;
  mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int   total = 0;
  int   passed = 0;
  int   cyc = 0;
  exp_t sb[$];

  logic [DW-1:0] exp_mem [logic [AW-1:0]];
  logic [DW-1:0] mem_arr [logic [AW-1:0]];
  logic [DW-1:0] last_if = '0;
  logic [DW-1:0] last_d = '0;

  int            waits = 0;
  bit            chk_mem = 0;
  bit            stray = 0;
  bit            exp_we = 0;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_wdata = '0;
  int            exp_mreq = 0;
  int            exp_busy = 0;
  int            hi_cnt = 0;
  int            maccess = 0;
  int            exp_access = 0;
  int            acks = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    else passed++;
  endtask

  function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
    if (exp_mem.exists(a)) return exp_mem[a];
    return DW'(a) ^ 19'h5A5A5;
  endfunction

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    if (mem_arr.exists(a)) return mem_arr[a];
    return DW'(a) ^ 19'h5A5A5;
  endfunction

  // Memory responder: counts BUSY cycles, answers after `waits` wait states.
  initial begin
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.mem_req) begin
        if (hi_cnt == 0) begin
          maccess++;
          if (chk_mem) check("mreq_cyc", cyc, exp_mreq);
        end
        if (chk_mem) begin
          check("mem_we", bus.mem_we, exp_we);
          check("mem_addr", bus.mem_addr, exp_addr);
          if (exp_we) check("mem_wdata", bus.mem_wdata, exp_wdata);
        end
        hi_cnt++;
        if (hi_cnt - 1 == waits) begin
          if (bus.mem_we) mem_arr[bus.mem_addr] = bus.mem_wdata;
          bus.mem_rdata = mem_rd(bus.mem_addr);
          bus.mem_ready = 1'b1;
        end else begin
          bus.mem_rdata = DW'($urandom);
          bus.mem_ready = 1'b0;
        end
      end else begin
        if (hi_cnt > 0 && chk_mem) check("busy_len", hi_cnt, exp_busy);
        hi_cnt = 0;
        bus.mem_rdata = DW'($urandom);
        bus.mem_ready = stray;
      end
    end
  end

  // Ack monitor: every ack pops one scoreboard entry.
  always @(negedge clk) begin
    if (bus.if_ack || bus.d_ack) begin
      acks++;
      check("ack_both", bus.if_ack & bus.d_ack, 0);
      if (sb.size() == 0) begin
        check("unexpected_ack", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("ack_sel", bus.d_ack, e.dat);
        check("err", bus.err, e.err);
        check("rdata", e.dat ? bus.d_rdata : bus.if_rdata, e.rdata);
        if (e.cyc >= 0) check("ack_cyc", cyc, e.cyc);
      end
    end else if (bus.err) begin
      check("err_without_ack", 1, 0);
    end
  end

  task automatic check_reset_vals();
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_if_ack", bus.if_ack, 0);
    check("rst_d_ack", bus.d_ack, 0);
    check("rst_err", bus.err, 0);
    check("rst_if_rdata", bus.if_rdata, 0);
    check("rst_d_rdata", bus.d_rdata, 0);
  endtask

  task automatic xact(input bit dat, input bit we, input logic [AW-1:0] a,
                      input logic [DW-1:0] wd, input int w);
    exp_t e;
    int   n;
    bit   got;
    bit   to;
    to = (w >= TO);
    @(posedge clk);
    #1;
    n         = cyc;
    waits     = w;
    exp_we    = dat & we;
    exp_addr  = a;
    exp_wdata = wd;
    exp_mreq  = n + 1;
    exp_busy  = to ? TO : w + 1;
    e.dat = dat;
    e.err = to;
    e.cyc = to ? n + 1 + TO : n + 2 + w;
    if (!dat) begin
      e.rdata = to ? '0 : model_rd(a);
      last_if = e.rdata;
    end else if (we) begin
      e.rdata = last_d;
      if (!to) exp_mem[a] = wd;
    end else begin
      e.rdata = to ? '0 : model_rd(a);
      last_d  = e.rdata;
    end
    sb.push_back(e);
    exp_access++;
    if (dat) begin
      bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = a; bus.d_wdata = wd;
    end else begin
      bus.if_req = 1'b1; bus.if_addr = a;
    end
    got = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if ((dat && bus.d_ack) || (!dat && bus.if_ack)) begin
        got = 1;
        break;
      end
    end
    if (!got) check("ack_wait", 0, 1);
    // Request stays high through the ack cycle and drops in the following IDLE cycle.
    @(posedge clk);
    #1;
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
  endtask

  initial begin
    exp_t e;
    int   n;
    int   k;
    bus.if_req = 0; bus.if_addr = '0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals();

    // Contention straight out of reset: data first, then alternating.
    waits = 0;
    reset = 1'b0;
    n = cyc;
    bus.if_req = 1'b1; bus.if_addr = 19'h00234;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 19'h01357;
    for (int i = 0; i < 4; i++) begin
      e.dat   = (i % 2 == 0);
      e.err   = 0;
      e.rdata = e.dat ? model_rd(19'h01357) : model_rd(19'h00234);
      e.cyc   = n + 2 + 3 * i;
      sb.push_back(e);
      exp_access++;
    end
    last_d  = model_rd(19'h01357);
    last_if = model_rd(19'h00234);
    k = 0;
    for (int c = 0; c < 80 && k < 4; c++) begin
      @(negedge clk);
      if (bus.if_ack || bus.d_ack) k++;
    end
    if (k < 4) check("contention_acks", k, 4);
    @(posedge clk);
    #1;
    bus.if_req = 0;
    bus.d_req  = 0;
    repeat (2) @(posedge clk);
    chk_mem = 1;

    // Fetch with zero-wait memory.
    exp_mem[19'h00010] = 19'h2A5F3;
    mem_arr[19'h00010] = 19'h2A5F3;
    xact(0, 0, 19'h00010, '0, 0);
    // Store with three wait states, then read it back.
    xact(1, 1, 19'h00100, 19'h7FFFF, 3);
    xact(1, 0, 19'h00100, '0, 1);
    // Memory never answers: timeout on a fetch and on a load.
    xact(0, 0, 19'h00444, '0, 1000);
    xact(1, 0, 19'h00555, '0, 1000);
    xact(1, 0, 19'h12345, '0, 2);

    // Stray mem_ready outside BUSY must be ignored.
    stray = 1;
    repeat (5) @(posedge clk);
    xact(0, 0, 19'h00777, '0, 2);
    stray = 0;

    // Reset in the second BUSY cycle aborts silently.
    chk_mem = 0;
    waits   = 1000;
    @(posedge clk);
    #1;
    bus.if_req = 1'b1; bus.if_addr = 19'h00999;
    exp_access++;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_reset_vals();
    reset = 1'b0;
    bus.if_req = 1'b0;
    last_if = '0;
    last_d  = '0;
    repeat (2) @(posedge clk);
    chk_mem = 1;
    xact(0, 0, 19'h00999, '0, 0);

    for (int i = 0; i < 6; i++) begin
      xact(1'($urandom), 1'($urandom), AW'($urandom), DW'($urandom), int'($urandom_range(0, 4)));
    end

    repeat (4) @(posedge clk);
    check("sb_empty", sb.size(), 0);
    check("mem_accesses", maccess, exp_access);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: AW, 19, address width.
REQ-002 Parameter: DW, 19, data width (CPU word).
REQ-003 Parameter: TIMEOUT, 16, max BUSY cycles awaiting mem_ready before abort.
REQ-004 Port: clk  input  1  single clock; all logic on rising edge.
REQ-005 Port: reset  input  1  synchronous, active-high reset.
REQ-006 Port: if_req  input  1  fetch request; held with if_addr stable until if_ack.
REQ-007 Port: if_addr  input  AW  fetch word address.
REQ-008 Port: if_ack  output  1  one-cycle pulse; fetch complete, if_rdata valid.
REQ-009 Port: if_rdata  output  DW  fetched instruction word.
REQ-010 Port: d_req  input  1  data request; held with d_we/d_addr/d_wdata stable until d_ack.
REQ-011 Port: d_we  input  1  1 = store, 0 = load.
REQ-012 Port: d_addr  input  AW  data word address.
REQ-013 Port: d_wdata  input  DW  store data.
REQ-014 Port: d_ack  output  1  one-cycle pulse; data access complete, d_rdata valid for loads.
REQ-015 Port: d_rdata  output  DW  load data.
REQ-016 Port: err  output  1  one-cycle pulse coincident with the ack of a timed-out access.
REQ-017 Port: mem_req  output  1  memory request, held until mem_ready.
REQ-018 Port: mem_we  output  1  memory write enable.
REQ-019 Port: mem_addr  output  AW  memory address.
REQ-020 Port: mem_wdata  output  DW  memory write data.
REQ-021 Port: mem_rdata  input  DW  memory read data, valid with mem_ready.
REQ-022 Port: mem_ready  input  1  memory completes current access this cycle.

Function
REQ-023 Single-port memory SHALL be shared between fetch and data requesters; one access outstanding at a time.
REQ-024 FSM states SHALL be IDLE, BUSY, RESP.
REQ-025 IDLE: if any req high, register grant and mem_* outputs from granted requester, go BUSY; else stay.
REQ-026 Only one req high in IDLE SHALL be granted regardless of history.
REQ-027 Both reqs high in IDLE SHALL grant the requester not recorded in last_grant (round-robin); last_grant updates on every grant.
REQ-028 BUSY: mem_req=1 with mem_we/mem_addr/mem_wdata constant; on mem_ready=1 capture mem_rdata into granted rdata register, clear mem_req, go RESP.
REQ-029 BUSY timeout counter SHALL start at 0 on entry and increment each BUSY cycle without mem_ready; when it reaches TIMEOUT-1 with no mem_ready, clear mem_req, load rdata with 0, set err for RESP, go RESP.
REQ-030 RESP: exactly one of if_ack/d_ack high for one cycle (the granted one), err high only if timed out; next state IDLE unconditionally.
REQ-031 Requests SHALL NOT be sampled in RESP, so a req still high in the ack cycle is not re-granted.
REQ-032 Latency: req first high cycle N with zero-wait memory (mem_ready high first BUSY cycle) -> mem_req high cycle N+1, ack high cycle N+2; each memory wait cycle adds one.
REQ-033 if_rdata/d_rdata SHALL hold their last captured value until next capture for that requester.
REQ-034 Store acks SHALL leave d_rdata unchanged.
REQ-035 mem_ready outside BUSY SHALL be ignored.
REQ-036 Back-to-back: continuous requests give one grant per BUSY+RESP+IDLE sequence (min 3 cycles per access).

Reset
REQ-037 On reset high at a clock edge: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, if_ack=0, d_ack=0, err=0, if_rdata=0, d_rdata=0, counter=0, last_grant=fetch.
REQ-038 Reset mid-access (BUSY or RESP) SHALL abort with no ack issued; requester re-requests after reset.

Verification
REQ-039 Fetch only, if_addr=0x00010, mem_ready immediate, mem_rdata=0x2A5F3 -> mem_req cycle N+1, if_ack cycle N+2, if_rdata=0x2A5F3, err=0.
REQ-040 if_req and d_req rise together from reset -> data granted first (last_grant=fetch), fetch granted next IDLE; alternates on continued contention.
REQ-041 Store d_addr=0x00100, d_wdata=0x7FFFF, mem_ready after 3 waits -> mem_we=1, mem_addr/mem_wdata stable 4 BUSY cycles, d_ack cycle N+5, d_rdata unchanged.
REQ-042 mem_ready never asserted -> mem_req deasserted after 16 BUSY cycles, ack with err=1 and rdata=0 next cycle, FSM back to IDLE.
REQ-043 reset asserted second BUSY cycle -> next cycle all outputs at reset values, no ack pulse, subsequent request served normally.
REQ-044 req held high through ack cycle then dropped -> exactly one ack, no duplicate memory access.
